line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Memory-side responder for the 4-way set-associative cache's miss path.
- The cache controller issues line refills (reads) and dirty-line writebacks (writes). This block accepts those requests, holds the backing line storage, and streams each 64-byte line as DATA_WIDTH beats with valid/ready handshakes.
- It serves as the main-memory endpoint for cache integration benches and as the behavioural model for the off-chip interface.

Parameters:
- ADDRESS_WIDTH, 32, request address width.
- DATA_WIDTH, 32, beat width in bits.
- LINE_SIZE_BYTES, 64, line size; BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH (16 at defaults).
- OFFSET_BITS, 6, byte-offset bits in the address (log2 LINE_SIZE_BYTES).
- MEM_LINES, 1024, number of lines stored (power of 2).
- READ_LATENCY, 4, idle cycles between read-request accept and the first read beat (0 allowed).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  request accepted when valid & ready.
- i_req_write  input  1  1 = writeback line, 0 = refill line.
- i_req_addr  input  ADDRESS_WIDTH  byte address; line index = i_req_addr[OFFSET_BITS +: log2(MEM_LINES)].
- i_wdata_valid  input  1  write beat valid.
- o_wdata_ready  output  1  write beat accepted when valid & ready.
- i_wdata  input  DATA_WIDTH  write beat data.
- o_rdata_valid  output  1  read beat valid.
- i_rdata_ready  input  1  read beat consumed when valid & ready.
- o_rdata  output  DATA_WIDTH  read beat data, registered.
- o_rdata_last  output  1  asserted with the final beat of a line.
- o_wack  output  1  one-cycle pulse when a writeback completes.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; beat counter and latency counter = 0.
  - o_req_ready = 1 after release. All other outputs = 0, including o_rdata.
  - Storage array is not reset.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_ACK.
- IDLE:
  - o_req_ready = 1; o_wdata_ready = 0.
  - Request accepted in cycle T latches the line index and the beat counter start (0).
  - Write request -> WR_BURST.
  - Read request with READ_LATENCY > 0 -> RD_WAIT, with the latency counter loaded to READ_LATENCY-1.
  - Read request with READ_LATENCY = 0 -> RD_BURST.
- RD_WAIT: counter decrements each cycle. When it reaches 0 -> RD_BURST, with beat 0 loaded into o_rdata. The first o_rdata_valid is in cycle T+1+READ_LATENCY.
- RD_BURST:
  - o_rdata_valid = 1. o_rdata and o_rdata_last are held stable while i_rdata_ready = 0.
  - On each handshake, the counter advances modulo BEATS and the next word is loaded.
  - o_rdata_last is high on the BEATS-th beat. Handshake on the last beat -> IDLE with o_rdata_valid = 0 the next cycle.
- WR_BURST:
  - o_wdata_ready = 1. Each handshake writes i_wdata to word[counter] of the latched line, and the counter increments.
  - Handshake on the BEATS-th beat -> WR_ACK.
  - Gaps (i_wdata_valid = 0) stall without side effects.
- WR_ACK: o_wack = 1 for exactly one cycle -> IDLE. The written line is readable by the next request.
- o_req_ready = 0 outside IDLE. Requests presented then are not accepted and are held by the requester. Write beats outside WR_BURST are ignored (ready = 0).
- Address handling:
  - Offset bits are ignored, except under the optional feature.
  - Tag bits above the index bits wrap modulo MEM_LINES, so addresses MEM_LINES*LINE_SIZE_BYTES apart alias.
- Reset mid-burst: the burst is abandoned immediately. Words written before reset are kept and the rest of the line is unchanged. No o_wack is issued.
- Read and write are never concurrent; read-after-write to the same line returns the new data.

Optional Feature:
- Macro: LINE_MEM_RESPONDER_CWF_EN (critical word first).
- Defined: on a read, the beat counter starts at i_req_addr[OFFSET_BITS-1 : log2(DATA_WIDTH/8)] and wraps modulo BEATS. o_rdata_last is asserted on the BEATS-th beat transferred, not on word BEATS-1. Writes always start at word 0.
- Undefined: all bursts start at word 0 and the offset is ignored.

Test Plan:
- Write line 0x0000_0040 with beats 0x100..0x10F (no gaps) -> o_wack exactly one cycle after the 16th beat. Then read 0x0000_0040 -> first beat 0x100 at T+5 (READ_LATENCY 4), o_rdata_last with 0x10F.
- Read with i_rdata_ready toggling 1,0,0,1 -> no beat lost or duplicated; o_rdata held stable while stalled; 16 handshakes total.
- Write with i_wdata_valid gaps every other cycle -> data intact; o_busy high throughout; o_req_ready = 0 until after o_wack.
- Alias check: write 0x0001_0040 (MEM_LINES = 1024) -> read 0x0000_0040 returns the same data.
- Assert rst low at beat 7 of a read -> all outputs 0 asynchronously, IDLE after release, next read of that line returns the full original line.
- CWF_EN defined: read 0x0000_0048 -> beats word 2..15 then 0..1 (0x102..0x10F, 0x100, 0x101), last on 0x101. CWF_EN undefined: same read starts at 0x100.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder: main-memory endpoint for the cache miss path.
// Accepts line refill (read) and writeback (write) requests, holds the backing
// line storage, and moves each line as BEATS beats over valid/ready handshakes.
// Optional feature: define LINE_MEM_RESPONDER_CWF_EN for critical-word-first
// reads (the read burst starts at the addressed word and wraps around the line).
module line_mem_responder #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_LINES       = 1024,
  parameter int READ_LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic                     i_wdata_valid,
  output logic                     o_wdata_ready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic                     o_rdata_valid,
  input  logic                     i_rdata_ready,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_rdata_last,
  output logic                     o_wack,
  output logic                     o_busy
);

  localparam int BEATS  = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int WORD_W = $clog2(BEATS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_ACK
  } state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [WORD_W-1:0]   word_reg;   // word address within the line
  logic [WORD_W-1:0]   xfer_reg;   // number of read beats already transferred
  logic [LAT_W-1:0]    lat_reg;

  // Flat storage: {line index, word index} addresses one beat-sized word.
  logic [DATA_WIDTH-1:0] mem [MEM_LINES*BEATS];

  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_start;
  logic [WORD_W-1:0] word_inc;
  logic [WORD_W-1:0] xfer_inc;
  logic              req_hs;
  logic              rd_hs;
  logic              wr_hs;
  logic              unused_addr;

  // Tag bits above the index are dropped, so addresses MEM_LINES lines apart alias.
  assign req_idx = i_req_addr[OFFSET_BITS +: IDX_W];
`ifdef LINE_MEM_RESPONDER_CWF_EN
  assign req_start = i_req_addr[BYTE_W +: WORD_W];
`else
  assign req_start = '0;
`endif
  assign unused_addr = ^i_req_addr;

  // Counters wrap naturally modulo BEATS.
  assign word_inc = word_reg + WORD_W'(1);
  assign xfer_inc = xfer_reg + WORD_W'(1);
  assign req_hs   = i_req_valid & o_req_ready;
  assign rd_hs    = o_rdata_valid & i_rdata_ready;
  assign wr_hs    = o_wdata_ready & i_wdata_valid;

  // Line storage: one word written per accepted write beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[{idx_reg, word_reg}] <= i_wdata;
    end
  end

  // Control FSM with registered outputs; read data is fetched one beat ahead of use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      word_reg      <= '0;
      xfer_reg      <= '0;
      lat_reg       <= '0;
      o_req_ready   <= 1'b0;
      o_wdata_ready <= 1'b0;
      o_rdata_valid <= 1'b0;
      o_rdata       <= '0;
      o_rdata_last  <= 1'b0;
      o_wack        <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_wack <= 1'b0;
      case (state_reg)
        IDLE: begin
          o_req_ready <= 1'b1;
          if (req_hs) begin
            idx_reg     <= req_idx;
            xfer_reg    <= '0;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            if (i_req_write) begin
              word_reg      <= '0;
              o_wdata_ready <= 1'b1;
              state_reg     <= WR_BURST;
            end else begin
              word_reg <= req_start;
              if (READ_LATENCY == 0) begin
                o_rdata       <= mem[{req_idx, req_start}];
                o_rdata_valid <= 1'b1;
                o_rdata_last  <= (LAST_WORD == '0);
                state_reg     <= RD_BURST;
              end else begin
                lat_reg   <= LAT_LOAD;
                state_reg <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (lat_reg == '0) begin
            o_rdata       <= mem[{idx_reg, word_reg}];
            o_rdata_valid <= 1'b1;
            o_rdata_last  <= (LAST_WORD == '0);
            state_reg     <= RD_BURST;
          end else begin
            lat_reg <= lat_reg - LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (rd_hs) begin
            if (o_rdata_last) begin
              o_rdata_valid <= 1'b0;
              o_rdata_last  <= 1'b0;
              o_busy        <= 1'b0;
              o_req_ready   <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              word_reg     <= word_inc;
              xfer_reg     <= xfer_inc;
              o_rdata      <= mem[{idx_reg, word_inc}];
              o_rdata_last <= (xfer_inc == LAST_WORD);
            end
          end
        end
        WR_BURST: begin
          if (wr_hs) begin
            word_reg <= word_inc;
            if (word_reg == LAST_WORD) begin
              o_wdata_ready <= 1'b0;
              o_wack        <= 1'b1;
              state_reg     <= WR_ACK;
            end
          end
        end
        WR_ACK: begin
          o_busy      <= 1'b0;
          o_req_ready <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed plus randomized bench for line_mem_responder.
// Keeps a word-array image of memory and predicts each read beat from it.
module tb_line_mem_responder;

  localparam int BEATS = 16;
  localparam int LINES = 1024;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [31:0] i_req_addr;
  logic        i_wdata_valid;
  logic        o_wdata_ready;
  logic [31:0] i_wdata;
  logic        o_rdata_valid;
  logic        i_rdata_ready;
  logic [31:0] o_rdata;
  logic        o_rdata_last;
  logic        o_wack;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [LINES][BEATS];
  bit          written [LINES];
  logic [31:0] pat     [BEATS];

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_write   (i_req_write),
    .i_req_addr    (i_req_addr),
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .o_rdata_valid (o_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .o_rdata       (o_rdata),
    .o_rdata_last  (o_rdata_last),
    .o_wack        (o_wack),
    .o_busy        (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr >> 6) % LINES);
  endfunction

  function automatic int start_of(input logic [31:0] addr);
`ifdef LINE_MEM_RESPONDER_CWF_EN
    return int'((addr >> 2) % BEATS);
`else
    return 0;
`endif
  endfunction

  // Called at a falling edge with the request already driven.
  task automatic accept_req();
    int cyc = 0;
    while (!o_req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_accept_timeout", 64'(cyc < 50), 1);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input bit gaps, input int abort_beat);
    int line = line_of(addr);
    int beat = 0;
    int cyc  = 0;
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = addr;
    accept_req();
    while (beat < BEATS && beat != abort_beat && cyc < 200) begin
      i_wdata_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      i_wdata       = gaps && (cyc % 2 != 0) ? $urandom : pat[beat];
      check("wr_ready", o_wdata_ready, 1);
      check("wr_busy", o_busy, 1);
      check("wr_req_ready", o_req_ready, 0);
      check("wr_wack_early", o_wack, 0);
      @(negedge clk);
      if (i_wdata_valid) begin
        ref_mem[line][beat] = pat[beat];
        beat++;
      end
      cyc++;
    end
    i_wdata_valid = 1'b0;
    if (abort_beat < 0) begin
      check("wr_beats", beat, BEATS);
      check("wack_pulse", o_wack, 1);
      check("wack_busy", o_busy, 1);
      check("wack_req_ready", o_req_ready, 0);
      @(negedge clk);
      check("wack_one_cycle", o_wack, 0);
      check("wr_idle_req_ready", o_req_ready, 1);
      check("wr_idle_busy", o_busy, 0);
      written[line] = 1'b1;
    end
    $display("write addr=%08h line=%0d gaps=%0d beats=%0d", addr, line, gaps, beat);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic do_read(input logic [31:0] addr, input int mode, input int abort_beat);
    int  line  = line_of(addr);
    int  start = start_of(addr);
    int  lat   = 0;
    int  k     = 0;
    int  cyc   = 0;
    bit  rdy;
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = addr;
    accept_req();
    while (!o_rdata_valid && lat < 50) begin
      check("rd_wait_busy", o_busy, 1);
      @(negedge clk);
      lat++;
    end
    check("rd_latency", lat, LAT);
    while (k < BEATS && k != abort_beat && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_rdata_ready = rdy;
      check("rd_valid", o_rdata_valid, 1);
      check("rd_data", o_rdata, ref_mem[line][(start + k) % BEATS]);
      check("rd_last", o_rdata_last, 64'(k == BEATS - 1));
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    i_rdata_ready = 1'b0;
    if (abort_beat < 0) begin
      check("rd_beats", k, BEATS);
      check("rd_end_valid", o_rdata_valid, 0);
      check("rd_end_busy", o_busy, 0);
      check("rd_end_req_ready", o_req_ready, 1);
    end
    $display("read  addr=%08h line=%0d start=%0d mode=%0d beats=%0d", addr, line, start, mode, k);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 0);
    check({tag, "_wdata_ready"}, o_wdata_ready, 0);
    check({tag, "_rdata_valid"}, o_rdata_valid, 0);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_rdata_last"}, o_rdata_last, 0);
    check({tag, "_wack"}, o_wack, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int line;
    logic [31:0] addr;
    rst           = 1'b1;
    i_req_valid   = 1'b0;
    i_req_write   = 1'b0;
    i_req_addr    = '0;
    i_wdata_valid = 1'b0;
    i_wdata       = '0;
    i_rdata_ready = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", o_req_ready, 1);
    check("post_reset_busy", o_busy, 0);

    // Write beats while idle must be refused and ignored
    i_wdata_valid = 1'b1;
    i_wdata       = 32'hDEAD_BEEF;
    check("idle_wdata_ready", o_wdata_ready, 0);
    @(negedge clk);
    i_wdata_valid = 1'b0;

    // Basic writeback then refill of line 0x40
    for (int i = 0; i < BEATS; i++) pat[i] = 32'h100 + 32'(i);
    do_write(32'h0000_0040, 1'b0, -1);
    do_read(32'h0000_0040, 0, -1);

    // Back-pressure pattern on the read side
    do_read(32'h0000_0040, 1, -1);

    // Write with gaps every other cycle, random data
    for (int i = 0; i < BEATS; i++) pat[i] = $urandom;
    do_write(32'h0000_0080, 1'b1, -1);
    do_read(32'h0000_0080, 2, -1);

    // Alias: 0x0001_0040 maps to the same line as 0x0000_0040
    for (int i = 0; i < BEATS; i++) pat[i] = 32'h200 + 32'(i);
    do_write(32'h0001_0040, 1'b0, -1);
    do_read(32'h0000_0040, 0, -1);

    // Restore 0x100.. and read from a non-zero offset
    for (int i = 0; i < BEATS; i++) pat[i] = 32'h100 + 32'(i);
    do_write(32'h0000_0040, 1'b0, -1);
    do_read(32'h0000_0048, 0, -1);

    // Reset in the middle of a read burst
    do_read(32'h0000_0040, 0, 7);
    #2 rst = 1'b0;
    #1 check_all_zero("rd_abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rd_abort_req_ready", o_req_ready, 1);
    check("rd_abort_busy", o_busy, 0);
    do_read(32'h0000_0040, 0, -1);

    // Reset in the middle of a write burst: first 5 words land, rest unchanged
    for (int i = 0; i < BEATS; i++) pat[i] = $urandom;
    do_write(32'h0000_0080, 1'b0, 5);
    #2 rst = 1'b0;
    #1 check_all_zero("wr_abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("wr_abort_no_wack", o_wack, 0);
    check("wr_abort_req_ready", o_req_ready, 1);
    do_read(32'h0000_0080, 2, -1);

    // Randomized traffic over a handful of lines with random tags and offsets
    for (int n = 0; n < 8; n++) begin
      line = $urandom_range(0, 7);
      for (int i = 0; i < BEATS; i++) pat[i] = $urandom;
      addr = (32'($urandom_range(0, 255)) << 16) | (32'(line) << 6) | 32'($urandom_range(0, 63));
      do_write(addr, 1'($urandom_range(0, 1)), -1);
      do begin
        line = $urandom_range(0, 7);
      end while (!written[line]);
      addr = (32'($urandom_range(0, 255)) << 16) | (32'(line) << 6) | 32'($urandom_range(0, 63));
      do_read(addr, $urandom_range(0, 2), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
